// File: rtl/caster_dither_pkg.sv
// rtl/caster_dither_pkg.sv - dither matrix periods and sizing helpers shared with the dither stage
package caster_dither_pkg;

  localparam int X_PERIOD_DES  = 3;
  localparam int Y_PERIOD_DES  = 6;
  localparam int X_PERIOD_MONO = 4;
  localparam int Y_PERIOD_MONO = 4;

  localparam int DATA_W  = 16;
  localparam int COORD_W = 3;
  localparam int ENTRY_W = DATA_W + 2 * COORD_W;

  // Any mode other than "MONO" selects the DES matrix.
  function automatic int x_period(input logic [31:0] mode);
    return (mode == "MONO") ? X_PERIOD_MONO : X_PERIOD_DES;
  endfunction

  function automatic int y_period(input logic [31:0] mode);
    return (mode == "MONO") ? Y_PERIOD_MONO : Y_PERIOD_DES;
  endfunction

  function automatic int wcnt_width(input int line_words);
    return (line_words > 2) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/dither_coord_gen_skid_buffer2.sv
// rtl/dither_coord_gen_skid_buffer2.sv - 2-entry valid/ready buffer, head entry is the output register
import caster_dither_pkg::*;

module skid_buffer2 #(
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             push;
  logic             pop;

  assign push    = s_valid && s_ready;
  assign pop     = (count != 2'd0) && m_ready;
  assign m_valid = (count != 2'd0);
  assign m_data  = head;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
  end

  // s_ready is registered from the next occupancy, so it is low exactly when both entries hold words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= 2'd0;
      s_ready <= 1'b0;
    end else begin
      count   <= count_next;
      s_ready <= (count_next != 2'd2);
      case (count)
        2'd0: begin
          if (push) head <= s_data;
        end
        2'd1: begin
          if (push && pop) begin
            head <= s_data;
          end else if (push) begin
            tail <= s_data;
          end
        end
        2'd2: begin
          if (pop) head <= tail;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dither_coord_gen.sv
// rtl/dither_coord_gen.sv - tags pixel words with dither matrix coordinates
// Optional frame-to-frame start-row rotation: DITHER_FRAME_ROTATE_EN.
import caster_dither_pkg::*;

module dither_coord_gen #(
  parameter logic [31:0] COLORMODE  = "DES",
  parameter int          LINE_WORDS = 400
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_sof,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic [COORD_W-1:0]   x_pos,
  output logic [COORD_W-1:0]   y_pos,
  output logic                 sof_err
);

  localparam int XP = x_period(COLORMODE);
  localparam int YP = y_period(COLORMODE);
  localparam int WW = wcnt_width(LINE_WORDS);

  localparam logic [WW-1:0]      WCNT_LAST = WW'(LINE_WORDS - 1);
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(XP - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(YP - 1);

  logic [WW-1:0]      wcnt;
  logic [COORD_W-1:0] xc;
  logic [COORD_W-1:0] yc;
  logic [COORD_W-1:0] phase;
  logic               accept;
  logic [COORD_W-1:0] tag_x;
  logic [COORD_W-1:0] tag_y;
  logic [ENTRY_W-1:0] buf_out;

  assign accept = s_valid && s_ready;

  // Tags come from the pre-increment state; SOF overrides both coordinates.
  always_comb begin
    tag_x = xc;
    tag_y = yc;
    if (s_sof) begin
      tag_x = '0;
      tag_y = phase;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt    <= '0;
      xc      <= '0;
      yc      <= '0;
      sof_err <= 1'b0;
    end else begin
      sof_err <= accept && s_sof && (wcnt != '0);
      if (accept) begin
        if (s_sof) begin
          wcnt <= WW'(1);
          xc   <= COORD_W'(1);
          yc   <= phase;
        end else if (wcnt == WCNT_LAST) begin
          wcnt <= '0;
          xc   <= '0;
          yc   <= (yc == Y_LAST) ? '0 : yc + COORD_W'(1);
        end else begin
          wcnt <= wcnt + WW'(1);
          xc   <= (xc == X_LAST) ? '0 : xc + COORD_W'(1);
        end
      end
    end
  end

`ifdef DITHER_FRAME_ROTATE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (accept && s_sof) begin
      phase <= (phase == Y_LAST) ? '0 : phase + COORD_W'(1);
    end
  end
`else
  assign phase = '0;
`endif

  skid_buffer2 #(
    .WIDTH(ENTRY_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data ({s_data, tag_x, tag_y}),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (buf_out)
  );

  assign {m_data, x_pos, y_pos} = buf_out;

endmodule

// File: doc/dither_coord_gen.md
# dither_coord_gen

Upstream neighbour of the ordered-dither stage. Accepts a valid/ready stream of 16-bit pixel words (four 4-bit pixels, MSB nibble first), tracks each word's position in the frame, and emits the word with its dither-matrix coordinates `x_pos`/`y_pos`, already reduced to the matrix period of the selected colour mode. Its outputs drive `vin`, `x_pos` and `y_pos` of the dither stage directly.

## Interface
- `COLORMODE`, `"DES"`: `"DES"` gives an x period of 3 and a y period of 6. `"MONO"` gives an x period of 4 and a y period of 4.
- `LINE_WORDS`, `400`: pixel words per line; legal range 2..4095.
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous, active-high.
- `s_valid` input 1: upstream word valid.
- `s_ready` output 1: block can accept a word.
- `s_data` input 16: upstream pixel word.
- `s_sof` input 1: qualified by `s_valid`; marks the first word of a frame.
- `m_valid` output 1: output word valid.
- `m_ready` input 1: downstream accepts the output word.
- `m_data` output 16: pixel word, connected to the dither stage `vin`.
- `x_pos` output 3: x coordinate of the `m_data` word.
- `y_pos` output 3: y coordinate of the `m_data` word.
- `sof_err` output 1: one-cycle pulse when a SOF word arrives mid-line.

## Operation
- A word is accepted when `s_valid && s_ready`. Counters update only on accept.
- State per accepted word:
  - `wcnt`: word index in the line, 0..LINE_WORDS-1.
  - `xc`: x coordinate, mod X period.
  - `yc`: y coordinate, mod Y period.
  - `phase`: frame start row, mod Y period.
- Coordinates are attached from the pre-increment state:
  - Normal word: `x_pos=xc`, `y_pos=yc`. Then `wcnt++` and `xc++` with wrap.
  - When `wcnt==LINE_WORDS-1`, the next state is `wcnt=0`, `xc=0`, `yc=(yc+1) mod Yp`.
- SOF word:
  - Coordinates are `x=0`, `y=phase`. Next state is `wcnt=1`, `xc=1`, `yc=phase`.
  - SOF takes priority over end-of-line wrap when both apply to the same word.
- `sof_err` pulses on the cycle after accepting a SOF word whose pre-accept `wcnt!=0` (short line). It does not fire for the first frame after reset.
- Data passes through unmodified, with no arithmetic on `s_data`.
- All outputs are zero after reset except `s_ready`. Reset values:
  - `m_valid=0`, `m_data=0`, `x_pos=0`, `y_pos=0`, `sof_err=0`.
  - `s_ready=1` from the first clock after `rst` deasserts.
  - All counters and `phase` are 0.
- Reset mid-frame discards buffered words. The first word accepted afterwards gets (0,0) even without SOF.

## Timing
- Latency is one cycle: a word accepted at edge N is on `m_*` with `m_valid=1` after edge N.
- Full throughput: one word per cycle while `m_ready=1`.
- Output register plus a 2-entry skid buffer:
  - `s_ready` is registered and depends only on buffer occupancy.
  - `s_ready` drops only when both entries are full.
- While `m_valid && !m_ready`, `m_data`, `x_pos` and `y_pos` are held stable.
- Coordinates always travel in the same buffer entry as their data word.
- Simultaneous push and pop when full is illegal by construction, because `s_ready=0` when full. Simultaneous push and pop with one entry keeps occupancy at 1.

## Configuration
- Macro: `DITHER_FRAME_ROTATE_EN`.
- Defined: each accepted SOF advances `phase` by 1 mod Yp, after its own word is tagged. The dither pattern start row therefore rotates frame-to-frame, which averages static pattern artefacts on the panel.
- Undefined: `phase` is the constant 0, so every frame starts at `y_pos=0`.

## Structure
- Package `caster_dither_pkg`:
  - `X_PERIOD_DES=3`, `Y_PERIOD_DES=6`, `X_PERIOD_MONO=4`, `Y_PERIOD_MONO=4`.
  - Function returning the period for a given `COLORMODE`.
  - Word-count width `$clog2(LINE_WORDS)`.
  - The dither stage uses the same constants.
- Sub-module `skid_buffer2`: a 2-entry valid/ready buffer of width 22 (16 data bits + 3 x bits + 3 y bits) with a registered `s_ready`. The top level holds only the counters, phase and error logic.

## Test plan
- **DES, LINE_WORDS=4, continuous stream, `m_ready=1`**:
  - SOF, then 12 words.
  - Required x sequence: 0,1,2,0 | 0,1,2,0 | 0,1,2,0.
  - Required y per line: 0, then 1, then 2.
  - Latency exactly one cycle.
- **MONO, LINE_WORDS=2, 10 lines**:
  - `y_pos` cycles 0,1,2,3,0,…
  - `x_pos` cycles 0,1 per line.
- **Backpressure**:
  - `m_ready` toggles randomly, 50%.
  - `m_data`, `x_pos` and `y_pos` stay stable while stalled.
  - No word is lost or duplicated; a scoreboard matches all 1000 words.
  - `s_ready` is low only with 2 entries buffered.
- **Short line**:
  - SOF arrives when `wcnt=2` (LINE_WORDS=4).
  - `sof_err` is a single-cycle pulse.
  - The SOF word gets `x=0`, `y=phase`.
- **SOF on last word of a line**:
  - SOF wins: word tagged (0, phase).
  - The next word gets `x=1` on the same row.
- **Reset mid-stream, with `DITHER_FRAME_ROTATE_EN`**:
  - Three SOFs produce first-word `y_pos` of 0,1,2.
  - Assert `rst` mid-line. Outputs go to their reset values immediately.
  - The next SOF word gets `y_pos=0`.
